// File: rtl/simplecpu_pkg.sv
// rtl/simplecpu_pkg.sv - shared constants and types for simplecpu and its program loader
package simplecpu_pkg;

  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int BUDGET_W  = 16;

  localparam logic [DATA_W-1:0] NOP_WORD = 8'h00;

  // Address counter is one bit wider than the RAM address so "all words done" is visible.
  localparam logic [ADDR_W:0] LEN_MAX = RAM_DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_RUN
  } loader_state_t;

endpackage

// File: rtl/loader_run_counter.sv
// rtl/loader_run_counter.sv - run-cycle budget counter; a zero budget never expires
module loader_run_counter
  import simplecpu_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic [BUDGET_W-1:0] i_budget,
  input  logic                i_en,
  output logic                o_expire
);

  logic [BUDGET_W-1:0] r_budget;
  logic [BUDGET_W-1:0] r_count;

  // Latch the budget and clear the count at sequence start; count enabled run cycles.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_budget <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_budget <= i_budget;
      r_count  <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expire on the last budgeted cycle; budget 0 means run until aborted.
  assign o_expire = i_en && (r_budget != '0) && (r_count == r_budget - 1'b1);

endmodule

// File: rtl/simplecpu_loader.sv
// rtl/simplecpu_loader.sv - loads a byte-stream program into simplecpu RAM, NOP-fills, then runs it
module simplecpu_loader
  import simplecpu_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [ADDR_W:0]     i_len,
  input  logic [BUDGET_W-1:0] i_budget,
  input  logic                i_abort,
  input  logic                i_in_valid,
  input  logic [DATA_W-1:0]   i_in_data,
  output logic                o_in_ready,
  output logic                o_load_ram,
  output logic [ADDR_W-1:0]   o_load_addr,
  output logic [DATA_W-1:0]   o_load_data,
  output logic                o_cpu_reset_n,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_aborted
);

  loader_state_t     r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_addr;
  logic              r_load_ram;
  logic [ADDR_W-1:0] r_load_addr;
  logic [DATA_W-1:0] r_load_data;
  logic              r_cpu_reset_n;
  logic              r_done;
  logic              r_aborted;

  logic [ADDR_W:0]   w_len_sat;
  logic [ADDR_W:0]   w_addr_next;
  logic              w_cnt_load;
  logic              w_cnt_en;
  logic              w_expire;

  assign w_len_sat   = (i_len > LEN_MAX) ? LEN_MAX : i_len;
  assign w_addr_next = r_addr + 1'b1;

  // The budget counts only cycles in which the CPU is actually out of reset.
  assign w_cnt_load = (r_state == ST_IDLE) && i_start;
  assign w_cnt_en   = (r_state == ST_RUN) && r_cpu_reset_n;

  loader_run_counter u_run_counter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (w_cnt_load),
    .i_budget (i_budget),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );

  // Sequencer: abort wins over everything; the first RUN cycle only releases CPU reset,
  // so the release lands one edge after the final write has been presented.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_addr        <= '0;
      r_load_ram    <= 1'b0;
      r_load_addr   <= '0;
      r_load_data   <= '0;
      r_cpu_reset_n <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_load_ram <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        r_state       <= ST_IDLE;
        r_cpu_reset_n <= 1'b0;
        r_aborted     <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cpu_reset_n <= 1'b0;
            if (i_start) begin
              r_len   <= w_len_sat;
              r_addr  <= '0;
              r_state <= (w_len_sat == '0) ? ST_FILL : ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (i_in_valid) begin
              r_load_ram  <= 1'b1;
              r_load_addr <= r_addr[ADDR_W-1:0];
              r_load_data <= i_in_data;
              r_addr      <= w_addr_next;
              if (w_addr_next == r_len) begin
                r_state <= (r_len == LEN_MAX) ? ST_RUN : ST_FILL;
              end
            end
          end
          ST_FILL: begin
            r_load_ram  <= 1'b1;
            r_load_addr <= r_addr[ADDR_W-1:0];
            r_load_data <= NOP_WORD;
            r_addr      <= w_addr_next;
            if (w_addr_next == LEN_MAX) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_expire) begin
              r_cpu_reset_n <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= ST_IDLE;
            end else begin
              r_cpu_reset_n <= 1'b1;
            end
          end
          default: begin
            r_state       <= ST_IDLE;
            r_cpu_reset_n <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_in_ready    = (r_state == ST_LOAD);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_load_ram    = r_load_ram;
  assign o_load_addr   = r_load_addr;
  assign o_load_data   = r_load_data;
  assign o_cpu_reset_n = r_cpu_reset_n;
  assign o_done        = r_done;
  assign o_aborted     = r_aborted;

endmodule

// File: tb/tb_simplecpu_loader.sv
// tb/tb_simplecpu_loader.sv - directed self-checking bench for simplecpu_loader
module tb_simplecpu_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic [15:0] budget = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, load_ram, cpu_reset_n, busy, done, aborted;
  logic [3:0]  load_addr;
  logic [7:0]  load_data;

  simplecpu_loader dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_len         (len),
    .i_budget      (budget),
    .i_abort       (abort),
    .i_in_valid    (in_valid),
    .i_in_data     (in_data),
    .o_in_ready    (in_ready),
    .o_load_ram    (load_ram),
    .o_load_addr   (load_addr),
    .o_load_data   (load_data),
    .o_cpu_reset_n (cpu_reset_n),
    .o_busy        (busy),
    .o_done        (done),
    .o_aborted     (aborted)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int hi_cnt, done_cnt, ab_cnt, overlap, cyc, start_cyc, first_hi_cyc;

  task automatic clear_obs();
    wa.delete(); wd.delete();
    hi_cnt = 0; done_cnt = 0; ab_cnt = 0; overlap = 0; first_hi_cyc = -1;
  endtask

  // One clock cycle: observe the outputs at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (load_ram) begin wa.push_back(load_addr); wd.push_back(load_data); end
    if (cpu_reset_n) begin
      hi_cnt++;
      if (first_hi_cyc < 0) first_hi_cyc = cyc;
    end
    if (done) done_cnt++;
    if (aborted) ab_cnt++;
    if (cpu_reset_n && load_ram) overlap++;
  endtask

  task automatic start_seq(input logic [4:0] l, input logic [15:0] b);
    start = 1'b1; len = l; budget = b;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int bound, output bit to);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    to = busy;
  endtask

  task automatic test_reset();
    tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", in_ready); else n_pass++;
    n_total++; if (load_ram !== 1'b0) $display("FAIL reset_load_ram got %0b want 0", load_ram); else n_pass++;
    n_total++; if (load_addr !== 4'h0) $display("FAIL reset_load_addr got %0h want 0", load_addr); else n_pass++;
    n_total++; if (load_data !== 8'h00) $display("FAIL reset_load_data got %0h want 0", load_data); else n_pass++;
    n_total++; if (cpu_reset_n !== 1'b0) $display("FAIL reset_cpu_reset_n got %0b want 0", cpu_reset_n); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if ({done, aborted} !== 2'b00) $display("FAIL reset_pulses got %0b want 00", {done, aborted}); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_len3();
    logic [7:0] bytes [3] = '{8'h51, 8'h80, 8'h90};
    bit to; int errs = 0;
    clear_obs();
    start_seq(5'd3, 16'd20);
    n_total++; if ({busy, in_ready, cpu_reset_n} !== 3'b110) $display("FAIL len3_enter_load got %0b want 110", {busy, in_ready, cpu_reset_n}); else n_pass++;
    for (int k = 0; k < 3; k++) begin in_valid = 1'b1; in_data = bytes[k]; tick(); end
    in_valid = 1'b0;
    wait_idle(200, to);
    n_total++; if (to) $display("FAIL len3_timeout busy still %0b want 0", busy); else n_pass++;
    n_total++; if (wa.size() !== 16) $display("FAIL len3_write_count got %0d want 16", wa.size()); else n_pass++;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 4'(i) || wd[i] !== ((i < 3) ? bytes[i] : 8'h00)) errs++;
    n_total++; if (errs !== 0) $display("FAIL len3_write_seq bad_words %0d want 0", errs); else n_pass++;
    n_total++; if (hi_cnt !== 20) $display("FAIL len3_run_cycles got %0d want 20", hi_cnt); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL len3_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (overlap !== 0) $display("FAIL len3_write_during_run got %0d want 0", overlap); else n_pass++;
    n_total++; if (first_hi_cyc - start_cyc !== 17) $display("FAIL len3_latency got %0d want 17", first_hi_cyc - start_cyc); else n_pass++;
  endtask

  task automatic test_len16_toggle();
    bit to; int errs = 0;
    clear_obs();
    start_seq(5'd16, 16'd4);
    for (int k = 0; k <= 30; k++) begin
      in_valid = (k % 2 == 0); in_data = 8'hA0 + 8'(k / 2); tick();
    end
    in_valid = 1'b0;
    n_total++; if ({in_ready, busy} !== 2'b01) $display("FAIL len16_run_entry got %0b want 01", {in_ready, busy}); else n_pass++;
    wait_idle(200, to);
    n_total++; if (to) $display("FAIL len16_timeout busy still %0b want 0", busy); else n_pass++;
    n_total++; if (wa.size() !== 16) $display("FAIL len16_write_count got %0d want 16", wa.size()); else n_pass++;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 4'(i) || wd[i] !== 8'hA0 + 8'(i)) errs++;
    n_total++; if (errs !== 0) $display("FAIL len16_write_seq bad_words %0d want 0", errs); else n_pass++;
    n_total++; if (hi_cnt !== 4) $display("FAIL len16_run_cycles got %0d want 4", hi_cnt); else n_pass++;
    n_total++; if (first_hi_cyc - start_cyc !== 32) $display("FAIL len16_latency got %0d want 32", first_hi_cyc - start_cyc); else n_pass++;
  endtask

  task automatic test_len0();
    bit to; int errs = 0;
    clear_obs();
    start_seq(5'd0, 16'd5);
    n_total++; if ({busy, in_ready} !== 2'b10) $display("FAIL len0_enter_fill got %0b want 10", {busy, in_ready}); else n_pass++;
    wait_idle(200, to);
    n_total++; if (to) $display("FAIL len0_timeout busy still %0b want 0", busy); else n_pass++;
    n_total++; if (wa.size() !== 16) $display("FAIL len0_write_count got %0d want 16", wa.size()); else n_pass++;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 4'(i) || wd[i] !== 8'h00) errs++;
    n_total++; if (errs !== 0) $display("FAIL len0_write_seq bad_words %0d want 0", errs); else n_pass++;
    n_total++; if (hi_cnt !== 5) $display("FAIL len0_run_cycles got %0d want 5", hi_cnt); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL len0_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (first_hi_cyc - start_cyc !== 17) $display("FAIL len0_latency got %0d want 17", first_hi_cyc - start_cyc); else n_pass++;
  endtask

  task automatic test_abort_load();
    clear_obs();
    start_seq(5'd5, 16'd10);
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; abort = 1'b1; tick();
    n_total++; if ({aborted, busy, cpu_reset_n} !== 3'b100) $display("FAIL abort_load_state got %0b want 100", {aborted, busy, cpu_reset_n}); else n_pass++;
    abort = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_total++; if (wa.size() !== 2) $display("FAIL abort_load_writes got %0d want 2", wa.size()); else n_pass++;
    n_total++; if (ab_cnt !== 1) $display("FAIL abort_load_pulses got %0d want 1", ab_cnt); else n_pass++;
    n_total++; if (hi_cnt !== 0) $display("FAIL abort_load_cpu_high got %0d want 0", hi_cnt); else n_pass++;
  endtask

  task automatic test_abort_vs_done();
    bit to; int n = 0;
    clear_obs();
    start_seq(5'd0, 16'd3);
    while (!cpu_reset_n && n < 100) begin tick(); n++; end
    n_total++; if (cpu_reset_n !== 1'b1) $display("FAIL race_run_timeout got %0b want 1", cpu_reset_n); else n_pass++;
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    n_total++; if ({aborted, done} !== 2'b10) $display("FAIL race_pulses got %0b want 10", {aborted, done}); else n_pass++;
    n_total++; if ({busy, cpu_reset_n} !== 2'b00) $display("FAIL race_idle got %0b want 00", {busy, cpu_reset_n}); else n_pass++;
    tick();
    clear_obs();
    start_seq(5'd2, 16'd2);
    in_valid = 1'b1; in_data = 8'h51; tick();
    in_data = 8'h80; tick();
    in_valid = 1'b0;
    wait_idle(200, to);
    n_total++; if (to) $display("FAIL restart_timeout busy still %0b want 0", busy); else n_pass++;
    n_total++; if (wa.size() !== 16) $display("FAIL restart_write_count got %0d want 16", wa.size()); else n_pass++;
    n_total++; if ({hi_cnt, done_cnt, ab_cnt} !== {32'd2, 32'd1, 32'd0}) $display("FAIL restart_run hi %0d done %0d ab %0d want 2 1 0", hi_cnt, done_cnt, ab_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    int n = 0;
    clear_obs();
    start_seq(5'd0, 16'd0);
    while (!cpu_reset_n && n < 100) begin tick(); n++; end
    for (int k = 0; k < 10; k++) tick();
    n_total++; if ({busy, cpu_reset_n} !== 2'b11) $display("FAIL unbounded_run got %0b want 11", {busy, cpu_reset_n}); else n_pass++;
    wa.delete(); wd.delete();
    start = 1'b1; len = 5'd3; budget = 16'd1;
    tick(); tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_total++; if ({busy, cpu_reset_n, in_ready} !== 3'b110) $display("FAIL start_in_run got %0b want 110", {busy, cpu_reset_n, in_ready}); else n_pass++;
    n_total++; if (wa.size() !== 0) $display("FAIL start_in_run_writes got %0d want 0", wa.size()); else n_pass++;
    n_total++; if (load_addr !== 4'hF) $display("FAIL pre_reset_addr got %0h want f", load_addr); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({busy, cpu_reset_n, in_ready, load_ram, done, aborted} !== 6'b0) $display("FAIL async_reset_ctl got %0b want 000000", {busy, cpu_reset_n, in_ready, load_ram, done, aborted}); else n_pass++;
    n_total++; if ({load_addr, load_data} !== 12'h000) $display("FAIL async_reset_bus got %0h want 000", {load_addr, load_data}); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    cyc = 0;
    clear_obs();
    test_reset();
    test_len3();
    test_len16_toggle();
    test_len0();
    test_abort_load();
    test_abort_vs_done();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
